mem_arbiter: RTL and testbench

// - Parametrised N-port memory arbiter/controller. It sits between the L1 caches (or other masters) and a

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port round-robin arbiter in front of a single backing-memory
// port with a fixed read latency. One transaction is in flight at a time.
//
// Ports
//   i_clock, i_reset        clock; synchronous active-high reset
//   i_req_valid/write       per-port request and direction (1 = write)
//   i_req_addr/wdata        per-port address/data, port i in slice i
//   o_stall                 per-port stall (request pending and not completing)
//   o_mem_read/write        one-cycle strobes to backing memory
//   o_mem_addr/wdata        latched address/data of the granted request
//   i_mem_rdata             read data, valid LATENCY cycles after o_mem_read
//   o_done, o_resp_port     one-cycle completion pulse and completed port index
//   o_resp_data             data of the last completed read (held)
module mem_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic [N_PORTS-1:0]                 i_req_valid,
    input  logic [N_PORTS-1:0]                 i_req_write,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]      i_req_wdata,
    output logic [N_PORTS-1:0]                 o_stall,
    output logic                               o_mem_read,
    output logic                               o_mem_write,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [DATA_WIDTH-1:0]              o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]              i_mem_rdata,
    output logic                               o_done,
    output logic [$clog2(N_PORTS)-1:0]         o_resp_port,
    output logic [DATA_WIDTH-1:0]              o_resp_data
);
    localparam int PW = $clog2(N_PORTS);
    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_port;
    logic                  r_write;
    logic [CW-1:0]         r_cnt;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic                  w_any;
    logic [PW-1:0]         w_grant;
    logic [PW-1:0]         w_rr_next;

    // Search rr_ptr, rr_ptr+1, ... (mod N_PORTS). Walking the offsets from
    // the far end lets the smallest offset overwrite, so it wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = PW'((int'(r_rr_ptr) + k) % N_PORTS);
            if (i_req_valid[idx]) begin
                w_any   = 1'b1;
                w_grant = idx;
            end
        end
    end

    assign w_rr_next = (w_grant == PW'(N_PORTS - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        o_stall = i_req_valid;
        for (int i = 0; i < N_PORTS; i++)
            o_stall[i] = i_req_valid[i] && !(r_done && (r_port == PW'(i)));
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_port      <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_resp_data <= '0;
        end else begin
            // Strobes and done are single-cycle pulses unless set below.
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port      <= w_grant;
                        r_write     <= i_req_write[w_grant];
                        r_mem_addr  <= i_req_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_wdata <= i_req_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
                        // Strobe is registered so it is visible during ISSUE.
                        r_mem_read  <= !i_req_write[w_grant];
                        r_mem_write <= i_req_write[w_grant];
                        r_rr_ptr    <= w_rr_next;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_write) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= CW'(LATENCY);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Count of 1 lines up with the LATENCY-th cycle after the strobe.
                    if (r_cnt == CW'(1)) begin
                        r_resp_data <= i_mem_rdata;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_done      = r_done;
    assign o_resp_port = r_port;
    assign o_resp_data = r_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model of mem_arbiter (4 ports, latency 2).
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int PW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_v = '0;
    logic [N-1:0]      req_w = '0;
    logic [N*AW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_d = '0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [N-1:0]      o_stall;
    logic              o_mem_read, o_mem_write, o_done;
    logic [AW-1:0]     o_mem_addr;
    logic [DW-1:0]     o_mem_wdata, o_resp_data;
    logic [PW-1:0]     o_resp_port;

    always #5 clk = ~clk;

    mem_arbiter #(.N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(L)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_v), .i_req_write(req_w), .i_req_addr(req_a), .i_req_wdata(req_d),
        .o_stall(o_stall), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata),
        .o_done(o_done), .o_resp_port(o_resp_port), .o_resp_data(o_resp_data)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // reference model: a granted transaction is a timeline t = 1..dur
    bit            m_busy = 0, m_wr = 0;
    int            m_t = 0, m_port = 0, m_rr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    bit            e_rd = 0, e_wr = 0, e_done = 0;
    int            e_port = 0;
    logic [DW-1:0] e_rdata = '0;

    // backing memory: one pending read return
    int            due = -1;
    logic [DW-1:0] due_data = '0;

    // observations of the DUT for directed checks
    int            ob_done_cyc = -1, ob_done_port = 0, ob_stb_cyc = 0, ob_stb_n = 0;
    logic [AW-1:0] ob_stb_addr = '0;
    logic [DW-1:0] ob_stb_wd = '0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic newreq(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_v[i] = 1'b1;
        req_w[i] = wr;
        req_a[i*AW +: AW] = a;
        req_d[i*DW +: DW] = d;
    endtask

    task automatic model_update();
        int dur, g;
        if (rst) begin
            m_busy = 0; m_rr = 0; e_rd = 0; e_wr = 0; e_done = 0; e_port = 0; e_rdata = '0;
        end else if (!m_busy) begin
            e_rd = 0; e_wr = 0; e_done = 0;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_v[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) begin
                m_busy = 1; m_t = 1; m_port = g; m_wr = req_w[g];
                m_addr = req_a[g*AW +: AW];
                m_wd   = req_d[g*DW +: DW];
                e_rd = !m_wr; e_wr = m_wr; e_port = g;
                m_rr = (g + 1) % N;
            end
        end else begin
            dur = m_wr ? 2 : L + 2;
            e_rd = 0; e_wr = 0;
            if (!m_wr && m_t == L + 1) e_rdata = memf(m_addr);
            if (m_t == dur) begin
                m_busy = 0; e_done = 0;
            end else begin
                m_t++;
                e_done = (m_t == dur);
            end
        end
    endtask

    // One clock cycle: drive memory, check outputs, advance the model.
    task automatic step();
        logic [N-1:0] exp_stall;
        mem_rdata = (cyc == due) ? due_data : DW'($urandom);
        #1;
        if (o_mem_read) begin due = cyc + L; due_data = memf(o_mem_addr); end
        if (o_mem_read || o_mem_write) begin
            if (ob_stb_n == 0) begin
                ob_stb_cyc = cyc; ob_stb_addr = o_mem_addr; ob_stb_wd = o_mem_wdata;
            end
            ob_stb_n++;
        end
        if (o_done) begin ob_done_cyc = cyc; ob_done_port = int'(o_resp_port); end
        chk("mem_read", o_mem_read, e_rd);
        chk("mem_write", o_mem_write, e_wr);
        chk("done", o_done, e_done);
        chk("resp_data", o_resp_data, e_rdata);
        if (m_busy) begin
            chk("mem_addr", o_mem_addr, m_addr);
            chk("mem_wdata", o_mem_wdata, m_wd);
        end
        if (e_done) chk("resp_port", o_resp_port, e_port);
        for (int i = 0; i < N; i++) exp_stall[i] = req_v[i] && !(e_done && e_port == i);
        chk("stall", o_stall, exp_stall);
        model_update();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_until_done(input bit keep, output int port, output int dcyc);
        ob_done_cyc = -1;
        for (int k = 0; k < 40 && ob_done_cyc < 0; k++) step();
        if (ob_done_cyc < 0) chk("done_timeout", 0, 1);
        port = ob_done_port;
        dcyc = ob_done_cyc;
        if (ob_done_cyc >= 0) begin
            if (keep) begin
                req_a[port*AW +: AW] = $urandom;
                req_d[port*DW +: DW] = $urandom;
            end else req_v[port] = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        req_v = '0; rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        int p, d, c0, prev;
        // reset held 3 cycles with random request lines
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            req_v = N'($urandom);
            step();
        end
        chk("rst_port", o_resp_port, 0);
        chk("rst_addr", o_mem_addr, 0);
        rst = 1'b0; req_v = '0;

        // port0 read of 0x10
        newreq(0, 1'b0, 32'h10, 32'h0);
        c0 = cyc; ob_stb_n = 0;
        run_until_done(0, p, d);
        chk("t2_rd_cyc", ob_stb_cyc - c0, 1);
        chk("t2_rd_n", ob_stb_n, 1);
        chk("t2_rd_addr", ob_stb_addr, 32'h10);
        chk("t2_done_cyc", d - c0, L + 2);
        chk("t2_port", p, 0);
        chk("t2_rdata", o_resp_data, 32'hDEADBEEF);

        // port1 write 0x20 / 0x55AA
        newreq(1, 1'b1, 32'h20, 32'h55AA);
        c0 = cyc; ob_stb_n = 0;
        run_until_done(0, p, d);
        chk("t4_wr_cyc", ob_stb_cyc - c0, 1);
        chk("t4_wr_n", ob_stb_n, 1);
        chk("t4_wr_addr", ob_stb_addr, 32'h20);
        chk("t4_wr_data", ob_stb_wd, 32'h55AA);
        chk("t4_done_cyc", d - c0, 2);
        chk("t4_port", p, 1);
        chk("t4_rdata_held", o_resp_data, 32'hDEADBEEF);

        // ports 0 and 1 requesting reads continuously from reset
        reset_pulse();
        newreq(0, 1'b0, $urandom, $urandom);
        newreq(1, 1'b0, $urandom, $urandom);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_until_done(1, p, d);
            chk("t3_order", p, i % 2);
            if (i > 0) chk("t3_period", d - prev, L + 3);
            prev = d;
        end
        req_v = '0;

        // reset during WAIT of a port0 read, then a port1-only request
        reset_pulse();
        newreq(0, 1'b0, 32'h40, 32'h0);
        step(); step();
        rst = 1'b1; step();
        rst = 1'b0; req_v = '0;
        chk("t5_no_done", o_done, 0);
        chk("t5_no_read", o_mem_read, 0);
        newreq(1, 1'b0, 32'h44, 32'h0);
        c0 = cyc;
        run_until_done(0, p, d);
        chk("t5_port", p, 1);
        chk("t5_done_cyc", d - c0, L + 2);

        // rr pointer now at 2: ports 1 and 3 together -> 3 first, then 1
        newreq(1, 1'b0, $urandom, $urandom);
        newreq(3, 1'b1, $urandom, $urandom);
        run_until_done(0, p, d);
        chk("t6_first", p, 3);
        run_until_done(0, p, d);
        chk("t6_second", p, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_v[i]) begin
                    if ($urandom_range(0, 3) == 0) newreq(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (m_busy && i == m_port) begin
                    if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
                end else if (m_busy && $urandom_range(0, 3) == 0) begin
                    req_a[i*AW +: AW] = $urandom;
                    req_d[i*DW +: DW] = $urandom;
                end
            end
            ob_done_cyc = -1;
            step();
            if (ob_done_cyc >= 0) req_v[ob_done_port] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
